// File: rtl/round_ctrl.sv
// Purpose: round sequencer and scorekeeper for the NOT NOT game; arms the judge, times the response, keeps score/lives.
// Latency: prepare_judge one cycle after start; answer sampled SETTLE_CYCLES+1 cycles after key release.
// Backpressure: none; start is only honoured in IDLE/OVER, key activity outside the response window is ignored.
module round_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned GAP_CYCLES     = 25000000,
  parameter int unsigned LIVES_INIT     = 3,
  parameter int unsigned SCORE_W        = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               key_pressed,
  input  logic               answer,
  output logic               prepare_judge,
  output logic               round_active,
  output logic               result_valid,
  output logic               result_ok,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] round_num,
  output logic [3:0]         lives,
  output logic               game_over
);

  // One shared down-counter serves the response window, settle delay and gap;
  // it is sized for the largest of the three loads.
  localparam int unsigned MAX_A    = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_LOAD = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
  localparam int unsigned CNT_W    = (MAX_LOAD > 1) ? $clog2(MAX_LOAD) : 1;

  localparam logic [CNT_W-1:0]   TO_LOAD   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   ST_LOAD   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [3:0]         LIVES_RST = 4'(LIVES_INIT);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] ONE       = SCORE_W'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_ARM, S_WAIT_KEY, S_WAIT_REL, S_SETTLE, S_SCORE, S_TIMEOUT, S_GAP, S_OVER
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] round_q, round_d;
  logic [3:0]         lives_q, lives_d;
  logic               ok_q, ok_d;

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      score_q <= '0;
      round_q <= '0;
      lives_q <= LIVES_RST;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      score_q <= score_d;
      round_q <= round_d;
      lives_q <= lives_d;
      ok_q    <= ok_d;
    end
  end

  // Next-state logic; a press in WAIT_KEY wins over an expiring window
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (start) state_d = S_ARM;
      S_ARM:      state_d = S_WAIT_KEY;
      S_WAIT_KEY: begin
        if (key_pressed)        state_d = S_WAIT_REL;
        else if (cnt_q == '0)   state_d = S_TIMEOUT;
      end
      S_WAIT_REL: if (!key_pressed) state_d = S_SETTLE;
      S_SETTLE:   if (cnt_q == '0) state_d = S_SCORE;
      S_SCORE,
      S_TIMEOUT:  state_d = S_GAP;
      S_GAP:      if (cnt_q == '0) state_d = (lives_q == 4'd0) ? S_OVER : S_ARM;
      S_OVER:     if (start) state_d = S_ARM;
      default:    state_d = S_IDLE;
    endcase
  end

  // Counter, score, lives and round bookkeeping; round values are updated on
  // the edge into ARM so they are already visible while prepare_judge is high
  always_comb begin
    cnt_d   = cnt_q;
    score_d = score_q;
    round_d = round_q;
    lives_d = lives_q;
    ok_d    = ok_q;
    unique case (state_q)
      S_ARM:      cnt_d = TO_LOAD;
      S_WAIT_KEY: if (!key_pressed && cnt_q != '0) cnt_d = cnt_q - 1'b1;
      S_WAIT_REL: if (!key_pressed) cnt_d = ST_LOAD;
      S_SETTLE:   if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      S_SCORE: begin
        cnt_d = GAP_LOAD;
        ok_d  = answer;
        if (answer) begin
          if (score_q != SCORE_MAX) score_d = score_q + ONE;
        end else if (lives_q != 4'd0) begin
          lives_d = lives_q - 4'd1;
        end
      end
      S_TIMEOUT: begin
        cnt_d = GAP_LOAD;
        ok_d  = 1'b0;
        if (lives_q != 4'd0) lives_d = lives_q - 4'd1;
      end
      S_GAP:      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      default:    cnt_d = cnt_q;
    endcase
    if (state_d == S_ARM && state_q != S_ARM) begin
      round_d = round_q + ONE;
      if (state_q == S_IDLE || state_q == S_OVER) begin
        score_d = '0;
        lives_d = LIVES_RST;
      end
      if (state_q == S_OVER) round_d = ONE;
    end
  end

  // Moore outputs decoded from the current state
  always_comb begin
    prepare_judge = 1'b0;
    round_active  = 1'b0;
    result_valid  = 1'b0;
    game_over     = 1'b0;
    unique case (state_q)
      S_ARM: begin
        prepare_judge = 1'b1;
        round_active  = 1'b1;
      end
      S_WAIT_KEY, S_WAIT_REL, S_SETTLE: round_active = 1'b1;
      S_GAP:   result_valid = 1'b1;
      S_OVER:  game_over    = 1'b1;
      default: round_active = 1'b0;
    endcase
  end

  assign result_ok = ok_q;
  assign score     = score_q;
  assign round_num = round_q;
  assign lives     = lives_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Purpose: self-checking bench for round_ctrl with a phase/timestamp game model.
// Latency: outputs compared on every falling edge against the model.
// Backpressure: not applicable.
module tb_round_ctrl;

  localparam int TO  = 20;
  localparam int ST  = 2;
  localparam int GAP = 4;
  localparam int LV  = 3;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       key_pressed = 1'b0;
  logic       answer = 1'b0;
  logic       prepare_judge, round_active, result_valid, result_ok, game_over;
  logic [7:0] score, round_num;
  logic [3:0] lives;

  int total = 0;
  int bad   = 0;

  round_ctrl #(
    .TIMEOUT_CYCLES(TO), .SETTLE_CYCLES(ST), .GAP_CYCLES(GAP),
    .LIVES_INIT(LV), .SCORE_W(8)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .key_pressed(key_pressed),
    .answer(answer), .prepare_judge(prepare_judge), .round_active(round_active),
    .result_valid(result_valid), .result_ok(result_ok), .score(score),
    .round_num(round_num), .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s: got %0d expected %0d at t=%0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases of a game: idle, round in progress (arm through settle), one-cycle
  // resolution, result display gap, game over. Timing inside a round is
  // tracked as the age (cycles since arm) and the age at which release was seen.
  localparam int P_IDLE = 0, P_ROUND = 1, P_RESOLVE = 2, P_GAP = 3, P_OVER = 4;

  int         ph = P_IDLE;
  int         age = 0;
  int         rel_age = 0;
  bit         pressed = 0, released = 0, timed_out = 0;
  bit         mdl_live = 0;
  logic [7:0] m_score = 0, m_round = 0;
  logic [3:0] m_lives = LV;
  logic       m_ok = 0;

  initial forever begin
    int nph;
    @(posedge clk);
    nph = ph;
    if (!resetn) begin
      nph = P_IDLE; m_score = 0; m_round = 0; m_lives = LV; m_ok = 0;
      mdl_live = 1;
    end else begin
      case (ph)
        P_IDLE, P_OVER: if (start) begin
          if (ph == P_OVER) m_round = 0;
          m_round = m_round + 8'd1;
          m_score = 0;
          m_lives = LV;
          nph = P_ROUND;
        end
        P_ROUND: if (age != 0) begin
          if (!pressed) begin
            if (key_pressed) pressed = 1;
            else if (age == TO) begin nph = P_RESOLVE; timed_out = 1; end
          end else if (!released) begin
            if (!key_pressed) begin released = 1; rel_age = age; end
          end else if (age == rel_age + ST) begin
            nph = P_RESOLVE; timed_out = 0;
          end
        end
        P_RESOLVE: begin
          if (timed_out) begin
            m_ok = 0; m_lives = m_lives - 4'd1;
          end else begin
            m_ok = answer;
            if (answer) begin
              if (m_score != 8'hFF) m_score = m_score + 8'd1;
            end else m_lives = m_lives - 4'd1;
          end
          nph = P_GAP;
        end
        P_GAP: if (age == GAP - 1) begin
          if (m_lives == 0) nph = P_OVER;
          else begin nph = P_ROUND; m_round = m_round + 8'd1; end
        end
        default: nph = P_IDLE;
      endcase
    end
    if (nph != ph) begin
      age = 0;
      if (nph == P_ROUND) begin pressed = 0; released = 0; end
    end else age++;
    ph = nph;
  end

  // Compare every cycle once the model has seen a reset edge
  initial forever begin
    @(negedge clk);
    if (mdl_live) begin
      chk("prepare_judge", {31'd0, prepare_judge}, {31'd0, (ph == P_ROUND && age == 0)});
      chk("round_active",  {31'd0, round_active},  {31'd0, (ph == P_ROUND)});
      chk("result_valid",  {31'd0, result_valid},  {31'd0, (ph == P_GAP)});
      chk("game_over",     {31'd0, game_over},     {31'd0, (ph == P_OVER)});
      chk("result_ok",     {31'd0, result_ok},     {31'd0, m_ok});
      chk("score",         {24'd0, score},         {24'd0, m_score});
      chk("round_num",     {24'd0, round_num},     {24'd0, m_round});
      chk("lives",         {28'd0, lives},         {28'd0, m_lives});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_prep(input int lim);
    int n = 0;
    while (prepare_judge !== 1'b1 && n < lim) begin step(); n++; end
    if (prepare_judge !== 1'b1) chk("wait_prep_timeout", 0, 1);
  endtask

  // Starts in an ARM cycle, ends in the first GAP cycle
  task automatic play_round(input logic ans, input int hold);
    step();
    key_pressed = 1'b1;
    repeat (hold) step();
    key_pressed = 1'b0;
    answer = ans;
    repeat (3) step();
    chk("score_cycle_active", {31'd0, round_active}, 0);
    step();
  endtask

  initial begin
    int n;
    int seg;
    // Reset and start
    repeat (3) step();
    chk("rst_prepare", {31'd0, prepare_judge}, 0);
    chk("rst_lives", {28'd0, lives}, 3);
    chk("rst_round", {24'd0, round_num}, 0);
    resetn = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_prepare", {31'd0, prepare_judge}, 1);
    chk("start_round", {24'd0, round_num}, 1);
    chk("mdl_start_round", {24'd0, m_round}, 1);
    chk("start_lives", {28'd0, lives}, 3);
    chk("start_active", {31'd0, round_active}, 1);

    // Correct answer after a 5-cycle hold
    play_round(1'b1, 5);
    chk("ok_score", {24'd0, score}, 1);
    chk("mdl_ok_score", {24'd0, m_score}, 1);
    chk("ok_result", {31'd0, result_ok}, 1);
    n = 0;
    while (result_valid && n < 20) begin n++; step(); end
    chk("gap_len", n, 4);
    chk("next_prepare", {31'd0, prepare_judge}, 1);
    chk("next_round", {24'd0, round_num}, 2);

    // Timeout: no key after arm
    n = 0;
    while (round_active && n < 100) begin step(); n++; end
    chk("timeout_len", n, 21);
    step();
    chk("to_lives", {28'd0, lives}, 2);
    chk("to_result", {31'd0, result_ok}, 0);
    chk("to_score", {24'd0, score}, 1);
    step();
    wait_prep(10);

    // Two wrong rounds take the remaining lives
    play_round(1'b0, 1);
    chk("wrong1_lives", {28'd0, lives}, 1);
    step();
    wait_prep(10);
    play_round(1'b0, 1);
    chk("wrong2_lives", {28'd0, lives}, 0);
    repeat (4) step();
    chk("over", {31'd0, game_over}, 1);
    key_pressed = 1'b1;
    repeat (3) step();
    key_pressed = 1'b0;
    n = 0;
    repeat (30) begin step(); if (prepare_judge) n++; end
    chk("over_no_prepare", n, 0);
    chk("over_hold", {31'd0, game_over}, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_prepare", {31'd0, prepare_judge}, 1);
    chk("restart_round", {24'd0, round_num}, 1);
    chk("restart_score", {24'd0, score}, 0);
    chk("restart_lives", {28'd0, lives}, 3);

    // Long hold beyond the response window
    repeat (10) step();
    key_pressed = 1'b1;
    n = 0;
    repeat (40) begin step(); if (!round_active) n++; end
    chk("hold_no_timeout", n, 0);
    key_pressed = 1'b0;
    answer = 1'b1;
    repeat (4) step();
    chk("hold_score", {24'd0, score}, 1);
    chk("hold_result", {31'd0, result_ok}, 1);
    step();
    wait_prep(10);
    play_round(1'b1, 2);
    chk("pre_rst_score", {24'd0, score}, 2);
    step();
    wait_prep(10);

    // Reset in the middle of a round
    step();
    key_pressed = 1'b1;
    repeat (2) step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("midrst_active", {31'd0, round_active}, 0);
    chk("midrst_score", {24'd0, score}, 0);
    chk("midrst_lives", {28'd0, lives}, 3);
    key_pressed = 1'b0;
    answer = 1'b1;
    repeat (10) step();
    chk("midrst_after_score", {24'd0, score}, 0);
    chk("midrst_after_round", {24'd0, round_num}, 0);

    // 260 quick correct rounds: score saturates, round_num wraps
    start = 1'b1;
    step();
    start = 1'b0;
    for (int r = 0; r < 260; r++) begin
      step();
      key_pressed = 1'b1;
      step();
      key_pressed = 1'b0;
      answer = 1'b1;
      step();
      wait_prep(20);
    end
    chk("sat_score", {24'd0, score}, 255);
    chk("wrap_round", {24'd0, round_num}, 5);
    chk("mdl_wrap_round", {24'd0, m_round}, 5);

    // Randomised play
    seg = 0;
    for (int i = 0; i < 3000; i++) begin
      if (seg == 0) begin
        key_pressed = 1'($urandom_range(0, 1));
        seg = $urandom_range(1, 25);
      end
      seg--;
      answer = 1'($urandom_range(0, 1));
      start  = ($urandom_range(0, 7) == 0);
      resetn = ($urandom_range(0, 499) != 0);
      step();
    end
    resetn = 1'b1;
    start = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
